mac_sequencer: RTL

- Drives one mac_array instance (the initiator side of its en/clear/bias/acc/valid interface).
- Accepts a cfg-latched job of N vector beats on an operand stream and issues clear plus en beats to the array.
- Captures the final accumulator, then requantizes it (round, arithmetic shift, saturate) to a DATA_W result.
- Hands the result downstream on a valid/ready port; sits between the DS-CNN operand fetch and the activation writeback.

---
 rtl/mac_seq_pkg.sv | 21 ++
 rtl/mac_requant.sv | 39 +++
 rtl/mac_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the mac_sequencer slice.
package mac_seq_pkg;
    localparam int SHIFT_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        WAIT,
        REQUANT,
        OUT
    } seq_state_t;

    function automatic int sat_max(input int dw);
        return (1 <<< (dw - 1)) - 1;
    endfunction

    function automatic int sat_min(input int dw);
        return -(1 <<< (dw - 1));
    endfunction
endpackage

// File: rtl/mac_requant.sv
// Accumulator requantizer: round-half-up, arithmetic shift, signed saturate.
// MAC_SEQ_RELU_EN fuses a ReLU ahead of saturation.
module mac_requant
    import mac_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic [SHIFT_W-1:0]       shift,
    output logic signed [DATA_W-1:0] res
);
    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(sat_max(DATA_W));
    localparam logic signed [ACC_W:0] MINV = (ACC_W+1)'(sat_min(DATA_W));

    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] shf;

    // One extra bit keeps the rounding add from wrapping at the top of the range.
    always_comb begin
        ext = {acc[ACC_W-1], acc};
        rnd = ext;
        if (shift != '0)
            rnd = ext + ((ACC_W+1)'(1) << (shift - 1'b1));
        shf = rnd >>> shift;
`ifdef MAC_SEQ_RELU_EN
        if (shf[ACC_W])
            shf = '0;
`else
`endif
        if (shf > MAXV)
            res = MAXV[DATA_W-1:0];
        else if (shf < MINV)
            res = MINV[DATA_W-1:0];
        else
            res = shf[DATA_W-1:0];
    end
endmodule

// File: rtl/mac_sequencer.sv
// Job sequencer driving one mac_array: clear, feed N beats, capture, requantize, hand off.
// Build with MAC_SEQ_RELU_EN to fuse ReLU into the requantizer.
module mac_sequencer
    import mac_seq_pkg::*;
#(
    parameter int N_MACS    = 16,
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 32,
    parameter int MAX_BEATS = 64,
    parameter int BEAT_W    = $clog2(MAX_BEATS + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [BEAT_W-1:0]              cfg_beats,
    input  logic signed [ACC_W-1:0]        cfg_bias,
    input  logic [SHIFT_W-1:0]             cfg_shift,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [0:N_MACS-1][DATA_W-1:0]  in_ifmap,
    input  logic [0:N_MACS-1][DATA_W-1:0]  in_weight,
    output logic                           mac_en,
    output logic                           mac_clear,
    output logic [0:N_MACS-1][DATA_W-1:0]  mac_ifmap,
    output logic [0:N_MACS-1][DATA_W-1:0]  mac_weight,
    output logic signed [ACC_W-1:0]        mac_bias,
    input  logic signed [ACC_W-1:0]        mac_acc,
    input  logic                           mac_valid,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [DATA_W-1:0]       out_data,
    output logic                           busy,
    output logic                           done,
    output logic                           seq_err
);
    seq_state_t state, nxt;

    logic [BEAT_W-1:0]        count;
    logic [BEAT_W-1:0]        beats_q;
    logic signed [ACC_W-1:0]  bias_q;
    logic [SHIFT_W-1:0]       shift_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [DATA_W-1:0] rq;

    assign mac_ifmap  = in_ifmap;
    assign mac_weight = in_weight;
    assign mac_bias   = bias_q;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt       = state;
        in_ready  = 1'b0;
        mac_en    = 1'b0;
        mac_clear = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:    if (start) nxt = CLEAR;
            CLEAR: begin
                mac_clear = 1'b1;
                nxt       = (beats_q != '0) ? FEED : WAIT;
            end
            FEED: begin
                in_ready = (count < beats_q);
                mac_en   = in_valid & in_ready;
                if (mac_en && (count + BEAT_W'(1) == beats_q))
                    nxt = WAIT;
            end
            WAIT:    nxt = REQUANT;
            REQUANT: nxt = OUT;
            OUT: begin
                out_valid = 1'b1;
                done      = out_ready;
                if (out_ready)
                    nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Config, beat count, captured accumulator and result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            beats_q  <= '0;
            bias_q   <= '0;
            shift_q  <= '0;
            acc_q    <= '0;
            out_data <= '0;
            seq_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    beats_q <= cfg_beats;
                    bias_q  <= cfg_bias;
                    shift_q <= cfg_shift;
                    count   <= '0;
                    seq_err <= 1'b0;
                end
                FEED: if (mac_en) count <= count + BEAT_W'(1);
                WAIT: begin
                    acc_q <= mac_acc;
                    if (beats_q != '0 && !mac_valid)
                        seq_err <= 1'b1;
                end
                REQUANT: out_data <= rq;
                default: ;
            endcase
        end
    end

    mac_requant #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_requant (
        .acc   (acc_q),
        .shift (shift_q),
        .res   (rq)
    );
endmodule
